i2s_rx_deserializer: RTL and testbench

Serial front end of the audio path: receives the codec's I2S stream (BCLK, LRCLK, SDATA), oversamples it on the system clock, and deserializes one stereo frame at a time into parallel left/right words. Each completed frame is presented together with a one-cycle `sample_valid` pulse. That pulse directly drives the sample-buffer stage's write clock, and the two words drive its left/right data inputs.

---
 rtl/i2s_rx_deserializer_if.sv | 26 ++
 rtl/i2s_rx_deserializer.sv | 167 ++++++++++++++++
 tb/tb_i2s_rx_deserializer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/i2s_rx_deserializer_if.sv
// Bundle of the I2S pins and the parallel sample outputs of i2s_rx_deserializer.
// The deserializer uses the master modport; the codec/consumer side uses slave.
interface i2s_rx_deserializer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  bclk;
    logic                  lrclk;
    logic                  sdata;
    logic [DATA_WIDTH-1:0] audio_data_left;
    logic [DATA_WIDTH-1:0] audio_data_right;
    // sample_valid is a one-cycle strobe with no ready/backpressure: the words
    // change only in the strobe cycle and hold until the next strobe.
    logic                  sample_valid;
    logic                  frame_error;
    logic [7:0]            err_count;

    modport master (
        input  bclk, lrclk, sdata,
        output audio_data_left, audio_data_right, sample_valid, frame_error, err_count
    );

    modport slave (
        output bclk, lrclk, sdata,
        input  audio_data_left, audio_data_right, sample_valid, frame_error, err_count
    );
endinterface

// File: rtl/i2s_rx_deserializer.sv
// Philips-I2S receiver: oversamples BCLK/LRCLK/SDATA on clk, emits one L/R word pair per frame.
// Optional short-slot detection (frame_error, err_count) is enabled by I2S_RX_FRAME_ERR_EN.
module i2s_rx_deserializer #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    i2s_rx_deserializer_if.master bus,
    output logic [1:0]            dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  DW_C    = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MSB_ONE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]            bclk_sync_q, lr_sync_q, sd_sync_q;
    logic                  bclk_prev_q;
    state_t                state_q, state_d;
    logic                  lr_prev_q, lr_prev_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] left_sr_q, left_sr_d, right_sr_q, right_sr_d;
    logic [DATA_WIDTH-1:0] left_q, left_d, right_q, right_d;
    logic                  valid_q;
    logic                  commit;

    logic                  bclk_rise, lr_s, sd_s, lr_change;
    logic [DATA_WIDTH-1:0] bit_mask;

    assign bclk_rise = bclk_sync_q[1] & ~bclk_prev_q;
    assign lr_s      = lr_sync_q[1];
    assign sd_s      = sd_sync_q[1];
    assign lr_change = lr_s ^ lr_prev_q;
    assign bit_mask  = MSB_ONE >> cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            sd_sync_q   <= '0;
            bclk_prev_q <= 1'b0;
            state_q     <= IDLE;
            lr_prev_q   <= 1'b0;
            cnt_q       <= '0;
            left_sr_q   <= '0;
            right_sr_q  <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[0], bus.bclk};
            lr_sync_q   <= {lr_sync_q[0], bus.lrclk};
            sd_sync_q   <= {sd_sync_q[0], bus.sdata};
            bclk_prev_q <= bclk_sync_q[1];
            state_q     <= state_d;
            lr_prev_q   <= lr_prev_d;
            cnt_q       <= cnt_d;
            left_sr_q   <= left_sr_d;
            right_sr_q  <= right_sr_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= commit;
        end
    end

    // A rise that shows an LRCLK change carries the previous slot's LSB, so it
    // only advances the FSM and restarts the counter; it never captures data.
    always_comb begin
        state_d    = state_q;
        lr_prev_d  = lr_prev_q;
        cnt_d      = cnt_q;
        left_sr_d  = left_sr_q;
        right_sr_d = right_sr_q;
        left_d     = left_q;
        right_d    = right_q;
        commit     = 1'b0;
        if (bclk_rise) begin
            lr_prev_d = lr_s;
            if (lr_change) begin
                cnt_d = '0;
                case (state_q)
                    IDLE: begin
                        if (!lr_s) begin
                            state_d   = LEFT;
                            left_sr_d = '0;
                        end
                    end
                    LEFT: begin
                        if (lr_s) begin
                            state_d    = RIGHT;
                            right_sr_d = '0;
                        end
                    end
                    RIGHT: begin
                        if (!lr_s) begin
                            commit    = 1'b1;
                            left_d    = left_sr_q;
                            right_d   = right_sr_q;
                            state_d   = LEFT;
                            left_sr_d = '0;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end else if (state_q != IDLE && cnt_q < DW_C) begin
                if (state_q == LEFT) begin
                    left_sr_d = sd_s ? (left_sr_q | bit_mask) : (left_sr_q & ~bit_mask);
                end else begin
                    right_sr_d = sd_s ? (right_sr_q | bit_mask) : (right_sr_q & ~bit_mask);
                end
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

`ifdef I2S_RX_FRAME_ERR_EN
    logic       short_l_q, short_l_d;
    logic       ferr_q, ferr_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       slot_short, left_end;

    assign slot_short = cnt_q < DW_C;
    assign left_end   = bclk_rise & lr_change & lr_s & (state_q == LEFT);

    always_comb begin
        short_l_d = short_l_q;
        ferr_d    = 1'b0;
        err_cnt_d = err_cnt_q;
        if (left_end) begin
            short_l_d = slot_short;
        end
        if (commit) begin
            ferr_d = short_l_q | slot_short;
            if (ferr_d && err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            short_l_q <= 1'b0;
            ferr_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            short_l_q <= short_l_d;
            ferr_q    <= ferr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.frame_error = ferr_q;
    assign bus.err_count   = err_cnt_q;
`else
    assign bus.frame_error = 1'b0;
    assign bus.err_count   = 8'd0;
`endif

    assign bus.audio_data_left  = left_q;
    assign bus.audio_data_right = right_q;
    assign bus.sample_valid     = valid_q;
    assign dbg_state_o          = state_q;
endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for i2s_rx_deserializer: drives I2S frames at clk = 8x bclk and
// checks every sample_valid pulse and the held outputs against an expected queue.
module tb_i2s_rx_deserializer;
    localparam int DW = 16;
    localparam int EW = 1 + 2*DW + 8;
`ifdef I2S_RX_FRAME_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] dbg_state;

    i2s_rx_deserializer_if #(.DATA_WIDTH(DW)) bus_if ();

    i2s_rx_deserializer #(.DATA_WIDTH(DW), .CNT_WIDTH(5)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus_if),
        .dbg_state_o (dbg_state)
    );

    // clock/reset
    always #5 clk = ~clk;

    // scoreboard state: entries are {frame_error, left, right, err_count}
    logic [EW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            m_err = 0;
    logic [DW-1:0] last_l = '0;
    logic [DW-1:0] last_r = '0;
    logic [7:0]    last_cnt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic send_bit(input logic lr, input logic d);
        bus_if.bclk  = 1'b0;
        bus_if.lrclk = lr;
        bus_if.sdata = d;
        repeat (4) @(negedge clk);
        bus_if.bclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // First bit of a slot stands for the previous word's LSB; pad bits are driven 1.
    task automatic send_slot(input logic lr, input logic [DW-1:0] data, input int nbits, input int len);
        send_bit(lr, 1'b1);
        for (int i = 0; i < nbits; i++) send_bit(lr, data[DW-1-i]);
        for (int i = nbits + 1; i < len; i++) send_bit(lr, 1'b1);
    endtask

    task automatic push_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit bad);
        bit fe;
        fe = ERR_EN && bad;
        if (fe && m_err < 255) m_err++;
        exp_q.push_back({fe, l, r, 8'(m_err)});
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_left"},  64'(bus_if.audio_data_left),  64'd0);
        check({tag, "_right"}, 64'(bus_if.audio_data_right), 64'd0);
        check({tag, "_valid"}, 64'(bus_if.sample_valid),     64'd0);
        check({tag, "_ferr"},  64'(bus_if.frame_error),      64'd0);
        check({tag, "_ecnt"},  64'(bus_if.err_count),        64'd0);
    endtask

    // monitor: pops on each pulse, otherwise outputs must hold the last committed values
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                last_l   = '0;
                last_r   = '0;
                last_cnt = '0;
            end
            if (bus_if.sample_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got sample_valid=1 L=%h R=%h expected no pulse",
                             bus_if.audio_data_left, bus_if.audio_data_right);
                end else begin
                    e = exp_q.pop_front();
                    check("frame", 64'({bus_if.frame_error, bus_if.audio_data_left,
                                        bus_if.audio_data_right, bus_if.err_count}), 64'(e));
                    last_l   = e[8+DW +: DW];
                    last_r   = e[8 +: DW];
                    last_cnt = e[7:0];
                end
            end else begin
                check("hold", 64'({bus_if.frame_error, bus_if.audio_data_left,
                                   bus_if.audio_data_right, bus_if.err_count}),
                      64'({1'b0, last_l, last_r, last_cnt}));
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no end of stimulus expected completion within 5ms");
        $fatal(1, "watchdog");
    end

    // stimulus
    initial begin
        bus_if.bclk  = 1'b0;
        bus_if.lrclk = 1'b1;
        bus_if.sdata = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("por");
        @(posedge clk);
        #2 reset_n = 1'b1;

        // stream begins mid-right-slot, then a full 32-BCLK frame
        repeat (6) send_bit(1'b1, 1'b1);
        send_slot(1'b0, 16'h1234, 16, 32);
        send_slot(1'b1, 16'hABCD, 16, 32);
        push_frame(16'h1234, 16'hABCD, 1'b0);

        // 12-bit left slot, 16-bit right slot: left LSBs zero-padded
        send_slot(1'b0, 16'hABC0, 12, 13);
        send_slot(1'b1, 16'h5555, 16, 17);
        push_frame(16'hABC0, 16'h5555, 1'b1);

        // back-to-back frames
        send_slot(1'b0, 16'h0001, 16, 32);
        send_slot(1'b1, 16'h8000, 16, 32);
        push_frame(16'h0001, 16'h8000, 1'b0);
        send_slot(1'b0, 16'hFFFF, 16, 32);
        send_slot(1'b1, 16'h0000, 16, 32);
        push_frame(16'hFFFF, 16'h0000, 1'b0);

        // start of a left slot commits the last frame; reset lands mid-slot
        send_bit(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) send_bit(1'b0, 1'(i & 1));
        wait_drain(100);
        @(posedge clk);
        #2 reset_n = 1'b0;
        m_err = 0;
        repeat (3) @(negedge clk);
        check_zero("midrst");
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("postrst");

        // remainder of the interrupted left slot and its right slot are not a full pair
        repeat (5) send_bit(1'b0, 1'b1);
        send_slot(1'b1, 16'h1111, 16, 32);
        send_slot(1'b0, 16'h2468, 16, 32);
        send_slot(1'b1, 16'h1357, 16, 32);
        push_frame(16'h2468, 16'h1357, 1'b0);

        // 300 short frames: 4-bit slots
        for (int i = 0; i < 300; i++) begin
            send_slot(1'b0, 16'hA000, 4, 5);
            send_slot(1'b1, 16'h5000, 4, 5);
            push_frame(16'hA000, 16'h5000, 1'b1);
        end
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        wait_drain(100);
        check("err_sat", 64'(bus_if.err_count), ERR_EN ? 64'd255 : 64'd0);
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
